stream_demux: RTL
=================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 8, payload width in bits (legal range 1..64).
REQ-003 Parameter N_CH, default 8, number of output channels (legal range 2..32, non-power-of-two allowed).
REQ-004 Derived constant SEL_W = max(1, clog2(N_CH)), select and pointer width.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 mode  in  1  0 = addressed (in_sel chooses channel), 1 = round-robin (rr_ptr chooses channel).
REQ-008 in_data  in  DATA_W  input payload.
REQ-009 in_sel  in  SEL_W  target channel, used in addressed mode only.
REQ-010 in_valid  in  1  input payload present.
REQ-011 in_ready  out  1  block accepts payload this cycle.
REQ-012 out_data  out  N_CH*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W].
REQ-013 out_valid  out  N_CH  per-channel payload present.
REQ-014 out_ready  in  N_CH  per-channel sink accepts.
REQ-015 rr_ptr  out  SEL_W  current round-robin target.
REQ-016 err_pulse  out  1  one-cycle pulse on a dropped (out-of-range) transfer.
REQ-017 drop_cnt  out  16  saturating count of dropped transfers.

Function
REQ-018 Target t SHALL be in_sel in addressed mode and rr_ptr in round-robin mode, re-evaluated combinationally every cycle.
REQ-019 Each channel SHALL hold one entry (valid bit plus DATA_W register).
REQ-020 in_ready SHALL be 1 when t >= N_CH, else (!out_valid[t] || out_ready[t]); in_ready SHALL NOT depend on in_valid.
REQ-021 Transfer occurs when in_valid && in_ready; for t < N_CH, out_data[t] and out_valid[t]=1 SHALL appear on the next clock (latency 1).
REQ-022 Channel drain occurs when out_valid[k] && out_ready[k]; without a same-cycle load into k, out_valid[k] SHALL clear on the next clock.
REQ-023 Simultaneous drain and load on the same channel SHALL keep out_valid[k]=1 and load the new payload (one transfer per cycle sustained).
REQ-024 out_data[k] SHALL remain stable while out_valid[k] && !out_ready[k]; non-target channels SHALL be unaffected by a transfer.
REQ-025 In round-robin mode, rr_ptr SHALL advance by one on each transfer, wrapping from N_CH-1 to 0; otherwise it SHALL hold, including in addressed mode.
REQ-026 rr_ptr SHALL be retained across mode changes.
REQ-027 In addressed mode, a transfer with in_sel >= N_CH SHALL be accepted and discarded, err_pulse SHALL be 1 on the next cycle only, and drop_cnt SHALL increment, saturating at 0xFFFF.
REQ-028 The upstream SHALL hold in_data and in_sel stable while in_valid && !in_ready; the bench SHALL assert this rule.

Reset
REQ-029 While rst_n=0, out_valid SHALL be all 0, out_data all 0, rr_ptr 0, err_pulse 0, drop_cnt 0, and in_ready SHALL be forced to 0.
REQ-030 Reset assertion mid-transfer SHALL discard all held entries immediately; the first transfer SHALL be possible on the first rising edge after deassertion.

Structure
REQ-031 Package stream_demux_pkg SHALL hold the mode encoding (MODE_ADDR=0, MODE_RR=1) and DROP_CNT_W=16.
REQ-032 Sub-module demux_slot (one-entry channel register with load/drain handshake) SHALL be instantiated N_CH times by a generate loop.
REQ-033 Target decode, in_ready mux, rr_ptr and drop counter SHALL reside in stream_demux.

Verification
REQ-034 Addressed mode, N_CH=8, all out_ready=1, in_sel=3, in_data=0xA5 for one cycle -> out_valid=8'b0000_1000 and channel 3 data=0xA5 next cycle, cleared the cycle after.
REQ-035 Backpressure: out_ready[5]=0, two transfers to channel 5 -> first accepted, in_ready=0 on the second until out_ready[5]=1, data 0x11 then 0x22 delivered in order.
REQ-036 Round-robin, 10 back-to-back transfers with data 0..9 -> channels 0..7 then 0,1 receive in order, rr_ptr ends at 2.
REQ-037 N_CH=6, addressed mode, in_sel=7 -> in_ready=1, no out_valid rises, err_pulse high for one cycle, drop_cnt=1; preload drop_cnt at 0xFFFF via 65535 drops -> remains 0xFFFF after one more.
REQ-038 Reset asserted while channels 2 and 4 hold data -> out_valid=0 asynchronously, rr_ptr=0, in_ready=0 until deassertion.
REQ-039 Simultaneous drain and load on channel 1 each cycle for 4 cycles -> out_valid[1] stays 1, payloads delivered without bubbles.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared mode encoding, counter width and select-width helper for the stream demux.
package stream_demux_pkg;

    localparam logic MODE_ADDR  = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   DROP_CNT_W = 16;

    function automatic int sel_width(input int n_ch);
        return ($clog2(n_ch) < 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Upstream/downstream bundle of the stream demux; slave is the demux, master the environment.
interface stream_demux_if #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 8
);
    import stream_demux_pkg::*;

    localparam int SEL_W = sel_width(N_CH);

    logic                   mode;
    logic [DATA_W-1:0]      in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_CH*DATA_W-1:0] out_data;
    logic [N_CH-1:0]        out_valid;
    logic [N_CH-1:0]        out_ready;
    logic [SEL_W-1:0]       rr_ptr;
    logic                   err_pulse;
    logic [DROP_CNT_W-1:0]  drop_cnt;

    modport master (
        output mode, in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr, err_pulse, drop_cnt
    );

    modport slave (
        input  mode, in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, rr_ptr, err_pulse, drop_cnt
    );

endinterface

// File: rtl/demux_slot.sv
// One-entry channel register: load appears on the next clock (latency 1).
// Accepts a load when empty or draining this cycle; data holds while stalled.
module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              drain_rdy,
    output logic              can_load,
    output logic              vld,
    output logic [DATA_W-1:0] dat
);

    assign can_load = !vld || drain_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (load) begin
            vld <= 1'b1;
            dat <= load_data;
        end else if (vld && drain_rdy) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Routes one input stream to N_CH one-entry channels by address or round-robin; latency 1.
// in_ready follows the target slot's room; out-of-range targets are always accepted and dropped.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_CH   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_demux_if.slave  bus
);

    localparam int SEL_W = sel_width(N_CH);
    localparam int PAD_W = 1 << SEL_W;
    localparam logic [SEL_W:0]   N_CH_L = N_CH[SEL_W:0];
    localparam logic [SEL_W-1:0] LAST_CH = N_CH_L[SEL_W-1:0] - SEL_W'(1);

    logic [SEL_W-1:0]       rr_ptr_q;
    logic [SEL_W-1:0]       tgt;
    logic                   tgt_ok;
    logic                   in_ready_c;
    logic                   xfer;
    logic                   drop;
    logic [N_CH-1:0]        can_load;
    logic [N_CH-1:0]        load;
    logic [PAD_W-1:0]       can_load_pad;
    logic [N_CH-1:0]        slot_vld;
    logic [N_CH*DATA_W-1:0] slot_dat;
    logic                   err_q;
    logic [DROP_CNT_W-1:0]  drop_q;

    assign tgt    = (bus.mode == MODE_RR) ? rr_ptr_q : bus.in_sel;
    assign tgt_ok = {1'b0, tgt} < N_CH_L;

    // Padding to a power of two keeps the mux index in range for non-power-of-two N_CH.
    assign can_load_pad = PAD_W'(can_load);
    assign in_ready_c   = rst_n && (!tgt_ok || can_load_pad[tgt]);
    assign xfer         = bus.in_valid && in_ready_c;
    assign drop         = xfer && !tgt_ok;

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        assign load[k] = xfer && tgt_ok && (tgt == SEL_W'(k));

        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (bus.in_data),
            .drain_rdy (bus.out_ready[k]),
            .can_load  (can_load[k]),
            .vld       (slot_vld[k]),
            .dat       (slot_dat[k*DATA_W +: DATA_W])
        );
    end

    // Pointer only moves on round-robin transfers, so it survives mode switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (xfer && bus.mode == MODE_RR) begin
            rr_ptr_q <= (rr_ptr_q == LAST_CH) ? '0 : rr_ptr_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            err_q <= drop;
            if (drop && drop_q != '1) begin
                drop_q <= drop_q + DROP_CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = slot_vld;
    assign bus.out_data  = slot_dat;
    assign bus.rr_ptr    = rr_ptr_q;
    assign bus.err_pulse = err_q;
    assign bus.drop_cnt  = drop_q;

endmodule
